// File: rtl/store_commit_buffer.sv
// Store commit buffer: compacts up to N committed stores per cycle into a circular FIFO,
// drains one store per cycle to data memory, and forwards word-covering stores to loads.
module store_commit_buffer #(
   parameter int N        = 2,
   parameter int SB_DEPTH = 8,
   parameter int XLEN     = 32
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [N-1:0]                    in_valid,
   input  logic [N-1:0][XLEN-1:0]          in_addr,
   input  logic [N-1:0][XLEN-1:0]          in_data,
   input  logic [N-1:0][1:0]               in_size,
   output logic                            sb_full,
   output logic [$clog2(SB_DEPTH+1)-1:0]   count,
   output logic                            overflow,
   output logic                            mem_req,
   output logic [XLEN-1:0]                 mem_addr,
   output logic [XLEN-1:0]                 mem_data,
   output logic [1:0]                      mem_size,
   input  logic                            mem_ack,
   input  logic [XLEN-1:0]                 ld_addr,
   output logic                            ld_hit,
   output logic [XLEN-1:0]                 ld_data,
   output logic                            ld_conflict
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = $clog2(SB_DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(SB_DEPTH - N);
   localparam logic [1:0] SIZE_WORD = 2'd2;

   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             overflow_reg, overflow_next;

   // Entry storage stays in registers: forwarding reads every slot in parallel.
   logic [XLEN-1:0] entry_addr [SB_DEPTH];
   logic [XLEN-1:0] entry_data [SB_DEPTH];
   logic [1:0]      entry_size [SB_DEPTH];

   logic [CNT_W-1:0] lane_pos  [N+1];
   logic [PTR_W-1:0] lane_slot [N];
   logic [1:0]       lane_size [N];
   logic [CNT_W-1:0] enq_count;
   logic             enq_any;
   logic             enq_fire;
   logic             deq_fire;

   // Each valid lane lands at tail plus the number of valid lanes below it.
   assign lane_pos[0] = '0;
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         assign lane_pos[gi+1] = lane_pos[gi] + CNT_W'(in_valid[gi]);
         assign lane_slot[gi]  = tail_reg + lane_pos[gi][PTR_W-1:0];
         assign lane_size[gi]  = (in_size[gi] == 2'd3) ? SIZE_WORD : in_size[gi];
      end
   endgenerate

   assign enq_count = lane_pos[N];
   assign enq_any   = |in_valid;
   assign sb_full   = (count_reg > FULL_LEVEL);
   assign enq_fire  = enq_any && !sb_full;
   assign mem_req   = (count_reg != '0);
   assign deq_fire  = mem_req && mem_ack;

   always_comb begin
      head_next     = head_reg;
      tail_next     = tail_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg || (enq_any && sb_full);
      if (enq_fire) begin
         tail_next  = tail_reg + enq_count[PTR_W-1:0];
         count_next = count_next + enq_count;
      end
      if (deq_fire) begin
         head_next  = head_reg + PTR_W'(1);
         count_next = count_next - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Occupancy is tracked by head/count, so payload needs no reset.
   always_ff @(posedge clock) begin
      if (!reset && enq_fire) begin
         for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
               entry_addr[lane_slot[i]] <= in_addr[i];
               entry_data[lane_slot[i]] <= in_data[i];
               entry_size[lane_slot[i]] <= lane_size[i];
            end
         end
      end
   end

   assign count    = count_reg;
   assign overflow = overflow_reg;
   assign mem_addr = mem_req ? entry_addr[head_reg] : '0;
   assign mem_data = mem_req ? entry_data[head_reg] : '0;
   assign mem_size = mem_req ? entry_size[head_reg] : 2'd0;

   logic [XLEN-1:0]  ld_word_addr;
   logic [PTR_W-1:0] fwd_slot;
   logic             match_found;
   logic             match_full;
   logic [XLEN-1:0]  match_data;

   assign ld_word_addr = ld_addr & ~XLEN'(3);

   // Walk oldest to youngest; the last match seen is the youngest one.
   always_comb begin
      fwd_slot    = head_reg;
      match_found = 1'b0;
      match_full  = 1'b0;
      match_data  = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         fwd_slot = head_reg + PTR_W'(k);
         if ((CNT_W'(k) < count_reg) &&
             (entry_addr[fwd_slot][XLEN-1:2] == ld_word_addr[XLEN-1:2])) begin
            match_found = 1'b1;
            match_full  = (entry_size[fwd_slot] == SIZE_WORD) &&
                          (entry_addr[fwd_slot] == ld_word_addr);
            match_data  = entry_data[fwd_slot];
         end
      end
   end

   assign ld_hit      = match_found && match_full;
   assign ld_conflict = match_found && !match_full;
   assign ld_data     = ld_hit ? match_data : '0;

endmodule
